// File: rtl/simon_pkg.sv
// Shared SIMON 32/64 constants, mode/state encodings and word-level helpers
// used by the UART SIMON bridge and its key expander.
package simon_pkg;

  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [15:0] C_CONST = 16'hFFFC;

  localparam logic [1:0] MODE_PASS     = 2'b00;
  localparam logic [1:0] MODE_ENC      = 2'b01;
  localparam logic [1:0] MODE_DEC      = 2'b10;
  localparam logic [1:0] MODE_PASS_ALT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_KEYEXP  = 3'd1,
    ST_PASS    = 3'd2,
    ST_COLLECT = 3'd3,
    ST_ROUND   = 3'd4,
    ST_EMIT    = 3'd5
  } state_t;

  function automatic logic [15:0] rol16(input logic [15:0] v, input int unsigned n);
    return (v << n) | (v >> (16 - n));
  endfunction

  function automatic logic [15:0] ror16(input logic [15:0] v, input int unsigned n);
    return (v >> n) | (v << (16 - n));
  endfunction

  function automatic logic [15:0] f(input logic [15:0] v);
    return (rol16(v, 1) & rol16(v, 8)) ^ rol16(v, 2);
  endfunction

  // Character i of the published z0 string, leftmost character is i = 0.
  function automatic logic z0_bit(input logic [5:0] i);
    return Z0[6'd61 - i];
  endfunction

  function automatic logic is_pass(input logic [1:0] m);
    return (m == MODE_PASS) || (m == MODE_PASS_ALT);
  endfunction

  function automatic logic [7:0] block_byte(input logic [31:0] b, input logic [1:0] idx);
    case (idx)
      2'd0:    return b[31:24];
      2'd1:    return b[23:16];
      2'd2:    return b[15:8];
      default: return b[7:0];
    endcase
  endfunction

  function automatic logic [31:0] block_put(input logic [31:0] b, input logic [1:0] idx,
                                            input logic [7:0] d);
    logic [31:0] r;
    r = b;
    case (idx)
      2'd0:    r[31:24] = d;
      2'd1:    r[23:16] = d;
      2'd2:    r[15:8]  = d;
      default: r[7:0]   = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/simon_key_expand.sv
// SIMON 32/64 key schedule: loads k0..k3, then derives one round key per
// step cycle; exposes a round-key read port and a ready flag.
module simon_key_expand
  import simon_pkg::*;
#(
  parameter int ROUNDS = 32,
  parameter int IDX_W  = $clog2(ROUNDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [63:0]      i_key,
  input  logic             i_step,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [15:0]      o_rd_key,
  output logic             o_last,
  output logic             o_key_ready
);

  localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(ROUNDS - 5);

  logic [15:0]      r_keys [ROUNDS];
  logic [IDX_W-1:0] r_cnt;
  logic             r_ready;
  logic [15:0]      w_t;
  logic [15:0]      w_new;

  // Next schedule word k[cnt+4] from k[cnt], k[cnt+1], k[cnt+3].
  always_comb begin
    w_t   = ror16(r_keys[r_cnt + IDX_W'(3)], 3) ^ r_keys[r_cnt + IDX_W'(1)];
    w_new = C_CONST ^ {15'd0, z0_bit(6'(r_cnt))} ^ r_keys[r_cnt] ^ w_t ^ ror16(w_t, 1);
  end

  // Key store, expansion counter and ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROUNDS; i++) begin
        r_keys[i] <= 16'h0000;
      end
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else if (i_load) begin
      r_keys[0] <= i_key[15:0];
      r_keys[1] <= i_key[31:16];
      r_keys[2] <= i_key[47:32];
      r_keys[3] <= i_key[63:48];
      r_cnt     <= '0;
      r_ready   <= (ROUNDS == 4);
    end else if (i_step) begin
      r_keys[r_cnt + IDX_W'(4)] <= w_new;
      if (r_cnt == LAST_CNT) begin
        r_cnt   <= '0;
        r_ready <= 1'b1;
      end else begin
        r_cnt <= r_cnt + IDX_W'(1);
      end
    end
  end

  assign o_rd_key    = r_keys[i_rd_idx];
  assign o_last      = (r_cnt == LAST_CNT);
  assign o_key_ready = r_ready;

endmodule

// File: rtl/uart_simon_bridge.sv
// Byte-stream bridge between UART RX and TX FIFOs: pass-through, or SIMON
// 32/64 encrypt/decrypt of 4-byte blocks with an iterative round engine.
module uart_simon_bridge
  import simon_pkg::*;
#(
  parameter int ROUNDS = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [63:0]      key_in,
  input  logic             key_load,
  input  logic             flush,
  input  logic [7:0]       read_data,
  input  logic             rx_empty,
  output logic             rd_uart,
  input  logic             tx_full,
  output logic [7:0]       write_data,
  output logic             wr_uart,
  output logic             key_ready,
  output logic             busy,
  output logic [CNT_W-1:0] block_count
);

  localparam int IDX_W = $clog2(ROUNDS);
  localparam logic [IDX_W-1:0] LAST_ROUND = IDX_W'(ROUNDS - 1);

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_mode, w_mode_nxt;
  logic [31:0]      r_block, w_block_nxt;
  logic [1:0]       r_bcnt, w_bcnt_nxt;
  logic [IDX_W-1:0] r_round, w_round_nxt;
  logic [CNT_W-1:0] r_block_count, w_block_count_nxt;

  logic             w_key_load;
  logic             w_key_step;
  logic             w_key_last;
  logic             w_key_ready;
  logic [IDX_W-1:0] w_rd_idx;
  logic [15:0]      w_rd_key;
  logic [15:0]      w_x;
  logic [15:0]      w_y;

  assign w_x      = r_block[31:16];
  assign w_y      = r_block[15:0];
  assign w_rd_idx = (r_mode == MODE_DEC) ? (LAST_ROUND - r_round) : r_round;

  simon_key_expand #(.ROUNDS(ROUNDS), .IDX_W(IDX_W)) u_key_expand (
    .clk         (clk_100MHz),
    .rst_n       (reset),
    .i_load      (w_key_load),
    .i_key       (key_in),
    .i_step      (w_key_step),
    .i_rd_idx    (w_rd_idx),
    .o_rd_key    (w_rd_key),
    .o_last      (w_key_last),
    .o_key_ready (w_key_ready)
  );

  // Next-state, datapath updates and FIFO strobes.
  always_comb begin
    w_state_nxt       = r_state;
    w_mode_nxt        = r_mode;
    w_block_nxt       = r_block;
    w_bcnt_nxt        = r_bcnt;
    w_round_nxt       = r_round;
    w_block_count_nxt = r_block_count;
    w_key_load        = 1'b0;
    w_key_step        = 1'b0;
    rd_uart           = 1'b0;
    wr_uart           = 1'b0;
    write_data        = 8'h00;
    case (r_state)
      ST_IDLE: begin
        if (key_load) begin
          w_key_load  = 1'b1;
          w_state_nxt = (ROUNDS > 4) ? ST_KEYEXP : ST_IDLE;
        end else if (!rx_empty) begin
          w_mode_nxt = mode;
          if (is_pass(mode)) begin
            w_state_nxt = ST_PASS;
          end else if (w_key_ready) begin
            w_state_nxt = ST_COLLECT;
            w_block_nxt = 32'h0000_0000;
            w_bcnt_nxt  = 2'd0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_KEYEXP: begin
        w_key_step  = 1'b1;
        w_state_nxt = w_key_last ? ST_IDLE : ST_KEYEXP;
      end
      ST_PASS: begin
        if (rx_empty) begin
          w_state_nxt = ST_IDLE;
        end else if (!tx_full) begin
          rd_uart    = 1'b1;
          wr_uart    = 1'b1;
          write_data = read_data;
        end else begin
          w_state_nxt = ST_PASS;
        end
      end
      ST_COLLECT: begin
        // Block was cleared on entry, so a flush leaves the tail zero-filled.
        if (flush && (r_bcnt != 2'd0)) begin
          w_state_nxt = ST_ROUND;
          w_round_nxt = '0;
        end else if (!rx_empty) begin
          rd_uart     = 1'b1;
          w_block_nxt = block_put(r_block, r_bcnt, read_data);
          if (r_bcnt == 2'd3) begin
            w_state_nxt = ST_ROUND;
            w_round_nxt = '0;
          end else begin
            w_bcnt_nxt = r_bcnt + 2'd1;
          end
        end else begin
          w_state_nxt = ST_COLLECT;
        end
      end
      ST_ROUND: begin
        if (r_mode == MODE_DEC) begin
          w_block_nxt = {w_y, w_x ^ f(w_y) ^ w_rd_key};
        end else begin
          w_block_nxt = {w_y ^ f(w_x) ^ w_rd_key, w_x};
        end
        if (r_round == LAST_ROUND) begin
          w_state_nxt = ST_EMIT;
          w_bcnt_nxt  = 2'd0;
        end else begin
          w_round_nxt = r_round + IDX_W'(1);
        end
      end
      ST_EMIT: begin
        if (!tx_full) begin
          wr_uart    = 1'b1;
          write_data = block_byte(r_block, r_bcnt);
          if (r_bcnt == 2'd3) begin
            w_state_nxt       = ST_IDLE;
            w_bcnt_nxt        = 2'd0;
            w_block_count_nxt = r_block_count + CNT_W'(1);
          end else begin
            w_bcnt_nxt = r_bcnt + 2'd1;
          end
        end else begin
          w_state_nxt = ST_EMIT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_mode        <= MODE_PASS;
      r_block       <= 32'h0000_0000;
      r_bcnt        <= 2'd0;
      r_round       <= '0;
      r_block_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_mode        <= w_mode_nxt;
      r_block       <= w_block_nxt;
      r_bcnt        <= w_bcnt_nxt;
      r_round       <= w_round_nxt;
      r_block_count <= w_block_count_nxt;
    end
  end

  assign key_ready   = w_key_ready;
  assign busy        = (r_state != ST_IDLE);
  assign block_count = r_block_count;

endmodule
